aes_dec_round_last: RTL

Final stage of the pipelined AES decryption datapath: applies InvShiftRows, InvSubBytes and AddRoundKey with round key 0, producing the plaintext block. It mirrors the encryption pipeline's initial key-add stage at the opposite end of the cipher. It accepts one block per cycle from the preceding inverse round and forwards enable/valid along the pipeline. It also keeps a running count of completed blocks.

---
 rtl/aes_dec_round_last.sv | 98 +++++++++
 1 files changed

// File: rtl/aes_dec_round_last.sv
// aes_dec_round_last: last AES decryption round (InvShiftRows, InvSubBytes, AddRoundKey with key 0).
// Define AES_DEC_LAST_PIPE_EN to insert a register stage between InvSubBytes and AddRoundKey.

module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // FIPS-197 inverse S-box, entry 0x00 in the most significant byte
  localparam logic [2047:0] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign y = TABLE[{~a, 3'b111} -: 8];
endmodule

module aes_dec_round_last #(
  parameter int BLOCK_LENGTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BLOCK_LENGTH-1:0] IN,
  input  logic [BLOCK_LENGTH-1:0] KEY,
  input  logic                    enable,
  output logic                    next_round_enable,
  output logic [BLOCK_LENGTH-1:0] OUT,
  output logic                    valid,
  output logic [15:0]             block_count
);
  logic [BLOCK_LENGTH-1:0] shifted;
  logic [BLOCK_LENGTH-1:0] subbed;
  logic [BLOCK_LENGTH-1:0] out_d;
  logic                    en_d;

  // byte b sits in row b%4, column b/4; row r is rotated right by r
  for (genvar b = 0; b < 16; b++) begin : g_byte
    localparam int ROW = b % 4;
    localparam int COL = b / 4;
    localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
    assign shifted[127-8*b -: 8] = IN[127-8*SRC -: 8];
    aes_inv_sbox u_inv_sbox (
      .a (shifted[127-8*b -: 8]),
      .y (subbed[127-8*b -: 8])
    );
  end

`ifdef AES_DEC_LAST_PIPE_EN
  logic [BLOCK_LENGTH-1:0] s1_sub;
  logic [BLOCK_LENGTH-1:0] s1_key;
  logic                    s1_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sub <= '0;
      s1_key <= '0;
      s1_en  <= 1'b0;
    end else begin
      s1_en  <= enable;
      s1_sub <= enable ? subbed : '0;
      s1_key <= enable ? KEY : '0;
    end
  end

  assign out_d = s1_sub ^ s1_key;
  assign en_d  = s1_en;
`else
  assign out_d = subbed ^ KEY;
  assign en_d  = enable;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OUT               <= '0;
      valid             <= 1'b0;
      next_round_enable <= 1'b0;
      block_count       <= 16'd0;
    end else begin
      OUT               <= en_d ? out_d : '0;
      valid             <= en_d;
      next_round_enable <= en_d;
      if (en_d) block_count <= block_count + 16'd1;
    end
  end
endmodule
